// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path: FSM state encoding, parity
// type constants, legal oversampling ratios and a small mid-bit helper.
// ----------------------------------------------------------------------------
package uart_pkg;

    // Receiver FSM state encoding
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    // Parity type selection
    localparam logic EVEN = 1'b0;
    localparam logic ODD  = 1'b1;

    // Supported oversampling ratios
    localparam logic [5:0] PRESCALE_X8  = 6'd8;
    localparam logic [5:0] PRESCALE_X16 = 6'd16;
    localparam logic [5:0] PRESCALE_X32 = 6'd32;

    // Edge count at the centre of a bit period
    function automatic logic [5:0] mid_point(input logic [5:0] prescale);
        return prescale >> 1;
    endfunction

    function automatic logic is_legal_prescale(input logic [5:0] prescale);
        return (prescale == PRESCALE_X8) || (prescale == PRESCALE_X16) ||
               (prescale == PRESCALE_X32);
    endfunction

endpackage

// File: rtl/rx_data_sampler.sv
// ----------------------------------------------------------------------------
// rx_data_sampler
// Captures the serial line around the centre of each bit period and resolves
// the bit value.
//
// Build option UART_RX_MAJORITY_EN:
//   defined   - three samples at mid-1, mid, mid+1; bit is the 2-of-3 majority
//   undefined - single sample at mid; only that sample register exists
//
// Ports:
//   i_clk          oversampling clock
//   i_rst_n        asynchronous active-low reset
//   i_edge_cnt     position within the current bit period
//   i_prescale     oversampling ratio latched at start detection
//   i_rx           serial line
//   o_bit          resolved bit value
//   o_sample_done  high once all samples of the current bit are captured
// ----------------------------------------------------------------------------
module rx_data_sampler
    import uart_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [5:0] i_edge_cnt,
    input  logic [5:0] i_prescale,
    input  logic       i_rx,
    output logic       o_bit,
    output logic       o_sample_done
);

    logic [5:0] w_mid;

    assign w_mid         = mid_point(i_prescale);
    // Last capture happens at mid+1, so the value is stable from mid+2 on
    assign o_sample_done = (i_edge_cnt >= (w_mid + 6'd2));

`ifdef UART_RX_MAJORITY_EN
    logic r_s0;
    logic r_s1;
    logic r_s2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s0 <= 1'b1;
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
        end else begin
            if (i_edge_cnt == (w_mid - 6'd1)) r_s0 <= i_rx;
            if (i_edge_cnt == w_mid)          r_s1 <= i_rx;
            if (i_edge_cnt == (w_mid + 6'd1)) r_s2 <= i_rx;
        end
    end

    assign o_bit = (r_s0 & r_s1) | (r_s0 & r_s2) | (r_s1 & r_s2);
`else
    logic r_s1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1 <= 1'b1;
        end else if (i_edge_cnt == w_mid) begin
            r_s1 <= i_rx;
        end
    end

    assign o_bit = r_s1;
`endif

endmodule

// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx
// UART receiver. Detects the start bit on an idle-high line, deserializes
// DATA_WIDTH bits LSB-first, optionally checks a parity bit and checks one
// stop bit. A good frame updates P_DATA with a one-cycle DATA_VALID strobe;
// parity and stop failures give one-cycle PAR_ERR / STP_ERR strobes instead.
//
// Build option UART_RX_MAJORITY_EN selects majority-of-three bit sampling
// inside rx_data_sampler; frame timing is the same either way.
//
// Ports:
//   CLK         oversampling clock (PRESCALE x baud)
//   RST         asynchronous active-low reset
//   RX_IN       serial line, already synchronous to CLK
//   PRESCALE    oversampling ratio (8, 16 or 32)
//   PAR_EN      parity bit present
//   PAR_TYP     0 = even, 1 = odd parity
//   P_DATA      last good received word
//   DATA_VALID  strobe, P_DATA updated this cycle
//   PAR_ERR     strobe, parity mismatch
//   STP_ERR     strobe, stop bit sampled low
// ----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [5:0]            PRESCALE,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  DATA_VALID,
    output logic                  PAR_ERR,
    output logic                  STP_ERR
);

    localparam int unsigned BCW = $clog2(DATA_WIDTH + 1);

    // State
    logic [2:0]            r_state;
    logic [5:0]            r_edge_cnt;
    logic [BCW-1:0]        r_bit_cnt;
    logic [5:0]            r_prescale;
    logic                  r_par_en;
    logic                  r_par_typ;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_frame_err;
    logic [DATA_WIDTH-1:0] r_p_data;
    logic                  r_data_valid;
    logic                  r_par_err;
    logic                  r_stp_err;

    // Next-state
    logic [2:0]            w_state_next;
    logic [5:0]            w_edge_cnt_next;
    logic [BCW-1:0]        w_bit_cnt_next;
    logic [5:0]            w_prescale_next;
    logic                  w_par_en_next;
    logic                  w_par_typ_next;
    logic [DATA_WIDTH-1:0] w_shift_next;
    logic                  w_frame_err_next;
    logic [DATA_WIDTH-1:0] w_p_data_next;
    logic                  w_data_valid_next;
    logic                  w_par_err_next;
    logic                  w_stp_err_next;

    logic w_sampled;
    logic w_sample_done;
    logic w_bit_val;
    logic w_bit_end;
    logic w_exp_par;
    logic w_last_data;

    rx_data_sampler u_sampler (
        .i_clk         (CLK),
        .i_rst_n       (RST),
        .i_edge_cnt    (r_edge_cnt),
        .i_prescale    (r_prescale),
        .i_rx          (RX_IN),
        .o_bit         (w_sampled),
        .o_sample_done (w_sample_done)
    );

    // 6-bit wrap keeps bit_end reachable for any prescale value, so the FSM
    // always finds its way back to IDLE even with an illegal ratio.
    assign w_bit_end   = (r_edge_cnt == (r_prescale - 6'd1));
    // An unresolved sample reads as idle level: a start bit aborts, data is
    // undefined anyway in that case.
    assign w_bit_val   = w_sample_done ? w_sampled : 1'b1;
    assign w_exp_par   = (r_par_typ == ODD) ? ~(^r_shift) : (^r_shift);
    assign w_last_data = (r_bit_cnt == BCW'(DATA_WIDTH - 1));

    always_comb begin
        w_state_next      = r_state;
        w_edge_cnt_next   = w_bit_end ? 6'd0 : (r_edge_cnt + 6'd1);
        w_bit_cnt_next    = r_bit_cnt;
        w_prescale_next   = r_prescale;
        w_par_en_next     = r_par_en;
        w_par_typ_next    = r_par_typ;
        w_shift_next      = r_shift;
        w_frame_err_next  = r_frame_err;
        w_p_data_next     = r_p_data;
        w_data_valid_next = 1'b0;
        w_par_err_next    = 1'b0;
        w_stp_err_next    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_edge_cnt_next = 6'd0;
                if (!RX_IN) begin
                    // The detection cycle is edge 0 of the start bit
                    w_state_next     = ST_START;
                    w_edge_cnt_next  = 6'd1;
                    w_bit_cnt_next   = '0;
                    w_frame_err_next = 1'b0;
                    w_prescale_next  = PRESCALE;
                    w_par_en_next    = PAR_EN;
                    w_par_typ_next   = PAR_TYP;
                end
            end

            ST_START: begin
                if (w_bit_end) begin
                    w_state_next = w_bit_val ? ST_IDLE : ST_DATA;
                end
            end

            ST_DATA: begin
                if (w_bit_end) begin
                    for (int i = 0; i < DATA_WIDTH; i++) begin
                        if (r_bit_cnt == BCW'(i)) w_shift_next[i] = w_bit_val;
                    end
                    w_bit_cnt_next = r_bit_cnt + BCW'(1);
                    if (w_last_data) begin
                        w_state_next = r_par_en ? ST_PARITY : ST_STOP;
                    end
                end
            end

            ST_PARITY: begin
                if (w_bit_end) begin
                    if (w_bit_val != w_exp_par) begin
                        w_par_err_next   = 1'b1;
                        w_frame_err_next = 1'b1;
                    end
                    w_state_next = ST_STOP;
                end
            end

            ST_STOP: begin
                if (w_bit_end) begin
                    if (!w_bit_val) begin
                        w_stp_err_next = 1'b1;
                    end else if (!r_frame_err) begin
                        w_p_data_next     = r_shift;
                        w_data_valid_next = 1'b1;
                    end
                    w_state_next = ST_IDLE;
                end
            end

            default: begin
                w_state_next    = ST_IDLE;
                w_edge_cnt_next = 6'd0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state      <= ST_IDLE;
            r_edge_cnt   <= 6'd0;
            r_bit_cnt    <= '0;
            r_prescale   <= PRESCALE_X8;
            r_par_en     <= 1'b0;
            r_par_typ    <= EVEN;
            r_shift      <= '0;
            r_frame_err  <= 1'b0;
            r_p_data     <= '0;
            r_data_valid <= 1'b0;
            r_par_err    <= 1'b0;
            r_stp_err    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_edge_cnt   <= w_edge_cnt_next;
            r_bit_cnt    <= w_bit_cnt_next;
            r_prescale   <= w_prescale_next;
            r_par_en     <= w_par_en_next;
            r_par_typ    <= w_par_typ_next;
            r_shift      <= w_shift_next;
            r_frame_err  <= w_frame_err_next;
            r_p_data     <= w_p_data_next;
            r_data_valid <= w_data_valid_next;
            r_par_err    <= w_par_err_next;
            r_stp_err    <= w_stp_err_next;
        end
    end

    assign P_DATA     = r_p_data;
    assign DATA_VALID = r_data_valid;
    assign PAR_ERR    = r_par_err;
    assign STP_ERR    = r_stp_err;

endmodule

// File: tb/tb_uart_rx.sv
// ----------------------------------------------------------------------------
// tb_uart_rx
// Directed, table-driven bench for uart_rx. Cycle 0 of a frame is the first
// clock period in which the receiver sees RX_IN low while idle; strobe cycles
// below are counted from there (absolute across back-to-back frames).
// ----------------------------------------------------------------------------
module tb_uart_rx;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [5:0] prescale;
    logic       par_en;
    logic       par_typ;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;

    uart_rx #(
        .DATA_WIDTH (8)
    ) dut (
        .CLK        (clk),
        .RST        (rst_n),
        .RX_IN      (rx),
        .PRESCALE   (prescale),
        .PAR_EN     (par_en),
        .PAR_TYP    (par_typ),
        .P_DATA     (p_data),
        .DATA_VALID (data_valid),
        .PAR_ERR    (par_err),
        .STP_ERR    (stp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         p;
        bit         pen;
        bit         ptyp;
        logic [7:0] data;
        bit         bad_par;   // send the inverted parity bit
        bit         stop_val;
        int         flip;      // frame cycle whose line level is inverted, -1 none
        bit         glitch;    // precede the frame with a 2-cycle low pulse
        bit         scramble;  // change config inputs mid-frame
        bit         b2b;       // next vector starts right after this one
        int         exp_dv;
        int         exp_pe;
        int         exp_se;
        logic [7:0] exp_pdata;
    } vec_t;

    localparam int NVEC = 11;
    vec_t vecs[NVEC];

    int n_cmp  = 0;
    int n_fail = 0;
    int base   = 0;
    int dv_cyc, pe_cyc, se_cyc, dv_n, pe_n, se_n;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold the line idle and require no strobes
    task automatic idle(input int n, input string name);
        int cnt;
        cnt = 0;
        rx  = 1'b1;
        for (int c = 0; c < n; c++) begin
            step();
            cnt += int'(data_valid) + int'(par_err) + int'(stp_err);
        end
        chk(name, cnt, 0);
    endtask

    task automatic run_frame(input vec_t v);
        int   nbits, len, k;
        logic pbit;
        logic val;
        nbits    = 2 + 8 + int'(v.pen);
        len      = nbits * v.p;
        pbit     = (^v.data) ^ v.ptyp ^ v.bad_par;
        dv_cyc   = -1; pe_cyc = -1; se_cyc = -1;
        dv_n     = 0;  pe_n   = 0;  se_n   = 0;
        prescale = 6'(v.p);
        par_en   = v.pen;
        par_typ  = v.ptyp;
        for (int c = 0; c < len; c++) begin
            k = c / v.p;
            if (k == 0)                   val = 1'b0;
            else if (k <= 8)              val = v.data[k-1];
            else if (v.pen && (k == 9))   val = pbit;
            else                          val = v.stop_val;
            if (c == v.flip) val = ~val;
            if (v.scramble && (c == v.p)) begin
                prescale = 6'd16;
                par_en   = ~v.pen;
                par_typ  = ~v.ptyp;
            end
            rx = val;
            step();
            if (data_valid) begin dv_n++; if (dv_cyc < 0) dv_cyc = base + c + 1; end
            if (par_err)    begin pe_n++; if (pe_cyc < 0) pe_cyc = base + c + 1; end
            if (stp_err)    begin se_n++; if (se_cyc < 0) se_cyc = base + c + 1; end
        end
        rx = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        int   len;
        //            p  pen ptyp data   bad stp flip gl sc b2b  dv   pe   se  pdata
        vecs[0]  = '{ 8, 0, 0, 8'hA5, 0, 1, -1, 0, 0, 0,  80,  -1,  -1, 8'hA5};
        vecs[1]  = '{16, 1, 0, 8'h3C, 1, 1, -1, 0, 0, 0,  -1, 160,  -1, 8'hA5};
        vecs[2]  = '{16, 1, 0, 8'h3C, 0, 1, -1, 0, 0, 0, 176,  -1,  -1, 8'h3C};
        vecs[3]  = '{16, 1, 1, 8'h3D, 0, 1, -1, 0, 0, 0, 176,  -1,  -1, 8'h3D};
        vecs[4]  = '{ 8, 0, 0, 8'h81, 0, 0, -1, 0, 0, 0,  -1,  -1,  80, 8'h3D};
        vecs[5]  = '{ 8, 0, 0, 8'h7E, 0, 1, -1, 0, 0, 0,  80,  -1,  -1, 8'h7E};
        vecs[6]  = '{ 8, 1, 0, 8'h01, 1, 0, -1, 0, 0, 0,  -1,  80,  88, 8'h7E};
        vecs[7]  = '{ 8, 0, 0, 8'h55, 0, 1, -1, 1, 1, 0,  80,  -1,  -1, 8'h55};
`ifdef UART_RX_MAJORITY_EN
        vecs[8]  = '{ 8, 0, 0, 8'hF0, 0, 1, 36, 0, 0, 0,  80,  -1,  -1, 8'hF0};
`else
        vecs[8]  = '{ 8, 0, 0, 8'hF0, 0, 1, 36, 0, 0, 0,  80,  -1,  -1, 8'hF8};
`endif
        vecs[9]  = '{32, 0, 0, 8'h12, 0, 1, -1, 0, 0, 1, 320,  -1,  -1, 8'h12};
        vecs[10] = '{32, 0, 0, 8'h34, 0, 1, -1, 0, 0, 0, 640,  -1,  -1, 8'h34};

        rst_n    = 1'b0;
        rx       = 1'b1;
        prescale = 6'd8;
        par_en   = 1'b0;
        par_typ  = 1'b0;
        repeat (3) step();
        chk("reset_p_data", int'(p_data), 0);
        chk("reset_data_valid", int'(data_valid), 0);
        chk("reset_par_err", int'(par_err), 0);
        chk("reset_stp_err", int'(stp_err), 0);
        rst_n = 1'b1;
        idle(5, "post_reset_idle");

        base = 0;
        for (int i = 0; i < NVEC; i++) begin
            v = vecs[i];
            if (v.glitch) begin
                rx = 1'b0;
                repeat (2) step();
                idle(20, $sformatf("v%0d_glitch_strobes", i));
            end
            run_frame(v);
            chk($sformatf("v%0d_dv_cycle", i), dv_cyc, v.exp_dv);
            chk($sformatf("v%0d_pe_cycle", i), pe_cyc, v.exp_pe);
            chk($sformatf("v%0d_se_cycle", i), se_cyc, v.exp_se);
            chk($sformatf("v%0d_dv_count", i), dv_n, (v.exp_dv >= 0) ? 1 : 0);
            chk($sformatf("v%0d_pe_count", i), pe_n, (v.exp_pe >= 0) ? 1 : 0);
            chk($sformatf("v%0d_se_count", i), se_n, (v.exp_se >= 0) ? 1 : 0);
            chk($sformatf("v%0d_p_data", i), int'(p_data), int'(v.exp_pdata));
            len = (2 + 8 + int'(v.pen)) * v.p;
            if (v.b2b) begin
                base += len;
            end else begin
                idle(5, $sformatf("v%0d_trailing_strobes", i));
                base = 0;
            end
        end

        // Reset in the middle of the data bits of a 0xA5 frame at PRESCALE 8
        prescale = 6'd8;
        par_en   = 1'b0;
        rx       = 1'b0;
        repeat (8) step();
        for (int c = 8; c < 30; c++) begin
            rx = 8'hA5 >> ((c / 8) - 1);
            step();
        end
        rst_n = 1'b0;
        rx    = 1'b1;
        #1;
        chk("midframe_reset_p_data", int'(p_data), 0);
        chk("midframe_reset_data_valid", int'(data_valid), 0);
        chk("midframe_reset_par_err", int'(par_err), 0);
        chk("midframe_reset_stp_err", int'(stp_err), 0);
        repeat (2) step();
        rst_n = 1'b1;
        idle(100, "post_midframe_reset_strobes");
        chk("post_midframe_reset_p_data", int'(p_data), 0);

        // Receiver must be clean again after the abandoned frame
        v = vecs[0];
        v.data = 8'h5A;
        base = 0;
        run_frame(v);
        chk("after_reset_dv_cycle", dv_cyc, 80);
        chk("after_reset_dv_count", dv_n, 1);
        chk("after_reset_err_count", pe_n + se_n, 0);
        chk("after_reset_p_data", int'(p_data), 8'h5A);
        idle(5, "final_trailing_strobes");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Receive half of the UART link. Recovers frames from the serial line using a PRESCALE-times oversampling clock and delivers each byte as a parallel word with a one-cycle valid strobe. Frames: start bit, DATA_WIDTH data bits LSB-first, optional parity bit, and one stop bit. It sits opposite the UART transmitter, and its P_DATA/DATA_VALID outputs feed the RX-side data synchronizer toward the system controller.

## Interface
- DATA_WIDTH, 8, data bits per frame
- CLK  in  1  oversampling clock; frequency is PRESCALE × baud rate
- RST  in  1  asynchronous, active-low reset
- RX_IN  in  1  serial line, idle high; already synchronous to CLK (synchronizer is upstream)
- PRESCALE  in  6  oversampling ratio; legal values are 8, 16 and 32
- PAR_EN  in  1  1 = parity bit present
- PAR_TYP  in  1  0 = even parity, 1 = odd parity
- P_DATA  out  DATA_WIDTH  last good received word; holds its value between frames
- DATA_VALID  out  1  one-cycle strobe; P_DATA is new in the same cycle
- PAR_ERR  out  1  one-cycle strobe: parity mismatch
- STP_ERR  out  1  one-cycle strobe: stop bit sampled low

## Operation
- **Reset:** all outputs go to 0, the FSM enters IDLE, and both counters clear. Reset mid-frame abandons the frame with no strobes.
- **Counters:**
  - edge_cnt runs 0..PRESCALE-1 within each bit.
  - bit_cnt counts the data bits received.
- **Sampling:** RX_IN is sampled at edge_cnt = PRESCALE/2-1, PRESCALE/2 and PRESCALE/2+1. The sampled bit is resolved by edge_cnt = PRESCALE/2+2.
- **IDLE:** on RX_IN = 0, latch PRESCALE, PAR_EN and PAR_TYP, then go to START. This cycle is edge_cnt 0.
- **START:** at edge_cnt = PRESCALE-1, a sampled 0 moves to DATA. A sampled 1 is a glitch: return to IDLE with no strobe.
- **DATA:** shift the sampled bit into bit position bit_cnt at each bit end. After DATA_WIDTH bits, go to PARITY if PAR_EN, else go to STOP.
- **PARITY:** the expected bit is XOR of the data bits for even parity, inverted for odd parity. On mismatch, PAR_ERR pulses at the bit end and a frame-error flag is set. The FSM always proceeds to STOP.
- **STOP:** at the bit end:
  - sampled 0: pulse STP_ERR.
  - sampled 1 and no frame error: load P_DATA and pulse DATA_VALID.
  - either way, go to IDLE.
- **Errored frames** never update P_DATA and never raise DATA_VALID.
- **Configuration changes:** PRESCALE/PAR_EN/PAR_TYP changes mid-frame are ignored; they take effect at the next start detection.
- **Back-to-back frames:** RX_IN low in the first IDLE cycle after STOP starts the next frame. No dead cycles are required.
- **Illegal PRESCALE:** values outside 8/16/32 give undefined data but the FSM must still return to IDLE.

## Timing
- Frame length is L = (2 + DATA_WIDTH + PAR_EN) × PRESCALE cycles, counted from the first low sample in IDLE (cycle 0).
- DATA_VALID, STP_ERR or PAR_ERR are registered outputs.
  - STP_ERR and DATA_VALID are high in cycle L.
  - PAR_ERR is high in cycle (1 + DATA_WIDTH + 1) × PRESCALE.
- **Examples:** 8N1 at PRESCALE = 8 gives a DATA_VALID high in cycle 80. 8E1 at PRESCALE = 16 gives 176.
- All strobes last exactly one cycle. PAR_ERR and STP_ERR may both fire in the same frame.

## Configuration
- **UART_RX_MAJORITY_EN**
  - Defined: the bit value is the 2-of-3 majority of the three mid-bit samples.
  - Undefined: the bit value is the single sample at edge_cnt = PRESCALE/2. The other two sample registers are not built.
  - Frame timing is identical in both builds.

## Structure
- **Shared package uart_pkg:**
  - FSM state encoding: IDLE, START, DATA, PARITY, STOP.
  - parity type constants: EVEN = 0, ODD = 1.
  - legal PRESCALE constants.
- **Sub-module rx_data_sampler:**
  - inputs: edge_cnt, the latched prescale and RX_IN.
  - outputs: the sampled bit and a sample-done flag.
  - contains the majority logic under UART_RX_MAJORITY_EN.
- The FSM, counters, deserializer shift register and parity/stop checks live in uart_rx itself.

## Test plan
- **Good frame:** PRESCALE = 8, PAR_EN = 0, send 0xA5 → DATA_VALID high in cycle 80 with P_DATA = 0xA5. No error strobes.
- **Parity:**
  - PRESCALE = 16, PAR_EN = 1, PAR_TYP = 0, send 0x3C with parity bit 1 (wrong) → PAR_ERR pulses in cycle 160. No DATA_VALID, and P_DATA keeps its old value.
  - Repeat with the correct parity bit 0 → DATA_VALID in cycle 176.
- **Stop error:** send 0x81 with the stop bit driven low → STP_ERR pulses in cycle L, no DATA_VALID. A following good frame of 0x7E is received correctly.
- **Start glitch:** RX_IN low for 2 cycles at PRESCALE = 8 → FSM returns to IDLE with no strobes. A subsequent frame of 0x55 decodes.
- **Majority vote** (macro defined): a one-cycle inverted pulse on the middle sample of data bit 3 of 0xF0 → P_DATA = 0xF0. With the macro undefined, the same stimulus gives 0xF8.
- **Reset and back-to-back:**
  - Assert RST mid-DATA → all outputs 0 and no strobes.
  - Two back-to-back 8N1 frames 0x12 and 0x34 at PRESCALE = 32 → DATA_VALID in cycles 320 and 640 with the matching P_DATA.
